// File: rtl/phy_rx_deserializer_if.sv
// Bundle of the two serial receive lanes and the recovered word stream.
// PHY_RX_WORD_COUNT_EN adds the word_count signal to the bundle.
interface phy_rx_deserializer_if;
    logic        data_in_0;
    logic        data_in_1;
    logic [31:0] data_out;
    logic        valid_out;
    logic        locked;
    logic        overflow;
`ifdef PHY_RX_WORD_COUNT_EN
    logic [15:0] word_count;

    modport master (output data_in_0, data_in_1,
                    input  data_out, valid_out, locked, overflow, word_count);
    modport slave  (input  data_in_0, data_in_1,
                    output data_out, valid_out, locked, overflow, word_count);
`else
    modport master (output data_in_0, data_in_1,
                    input  data_out, valid_out, locked, overflow);
    modport slave  (input  data_in_0, data_in_1,
                    output data_out, valid_out, locked, overflow);
`endif
endinterface

// File: rtl/phy_rx_deserializer.sv
// Two-lane receive deserializer: COM alignment, byte framing, 32-bit word assembly,
// per-lane skew FIFOs and lane-0/lane-1 un-striping. PHY_RX_WORD_COUNT_EN adds word_count.
module phy_rx_deserializer #(
    parameter logic [7:0] COM_SYM    = 8'hBC,
    parameter int         LOCK_COMS  = 4,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    phy_rx_deserializer_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

    typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} lane_state_e;

    logic [1:0]  lane_bit;
    logic [1:0]  lane_locked;
    logic [1:0]  fifo_nonempty;
    logic [1:0]  fifo_pop;
    logic [1:0]  overflow_hit;
    logic [31:0] fifo_rd_data [2];

    assign lane_bit = {bus.data_in_1, bus.data_in_0};

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        lane_state_e   state_q, state_d;
        logic [7:0]    shreg_q, shreg_d;
        logic [2:0]    bit_cnt_q, bit_cnt_d;
        logic [3:0]    com_cnt_q, com_cnt_d;
        logic [1:0]    byte_idx_q, byte_idx_d;
        logic [23:0]   word_q, word_d;
        logic          push_q, push_d;
        logic [31:0]   push_data_q, push_data_d;
        logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [PW:0]   count_q, count_d;
        logic [31:0]   mem [FIFO_DEPTH];
        logic          byte_done, full, wr_en;

        assign byte_done = (bit_cnt_q == 3'd7);

        always_comb begin
            shreg_d     = {shreg_q[6:0], lane_bit[gi]};
            state_d     = state_q;
            bit_cnt_d   = bit_cnt_q + 3'd1;
            com_cnt_d   = com_cnt_q;
            byte_idx_d  = byte_idx_q;
            word_d      = word_q;
            push_d      = 1'b0;
            push_data_d = push_data_q;
            unique case (state_q)
                SEARCH: if (shreg_d == COM_SYM) begin
                    state_d   = SYNC;
                    bit_cnt_d = 3'd0;
                    com_cnt_d = 4'd1;
                end
                SYNC: if (byte_done) begin
                    if (shreg_d == COM_SYM) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_d == 4'(LOCK_COMS)) begin
                            state_d    = LOCKED;
                            byte_idx_d = 2'd0;
                        end
                    end else begin
                        state_d   = SEARCH;
                        com_cnt_d = 4'd0;
                    end
                end
                // A COM in the first byte slot is idle; later slots take any value.
                LOCKED: if (byte_done && !(byte_idx_q == 2'd0 && shreg_d == COM_SYM)) begin
                    word_d     = {word_q[15:0], shreg_d};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        push_d      = 1'b1;
                        push_data_d = {word_q, shreg_d};
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
        assign full               = (count_q == DEPTH_C);
        assign wr_en              = push_q && (!full || fifo_pop[gi]);
        assign overflow_hit[gi]   = push_q && full && !fifo_pop[gi];
        assign fifo_nonempty[gi]  = (count_q != '0);
        assign fifo_rd_data[gi]   = mem[rd_ptr_q];
        assign lane_locked[gi]    = (state_q == LOCKED);

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (wr_en)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (fifo_pop[gi])
                rd_ptr_d = rd_ptr_q + PW'(1);
            if (wr_en && !fifo_pop[gi])
                count_d = count_q + (PW+1)'(1);
            else if (!wr_en && fifo_pop[gi])
                count_d = count_q - (PW+1)'(1);
        end

        always_ff @(posedge clk_32f) begin
            if (wr_en)
                mem[wr_ptr_q] <= push_data_q;
        end

        always_ff @(posedge clk_32f or negedge reset) begin
            if (!reset) begin
                state_q     <= SEARCH;
                shreg_q     <= '0;
                bit_cnt_q   <= '0;
                com_cnt_q   <= '0;
                byte_idx_q  <= '0;
                word_q      <= '0;
                push_q      <= 1'b0;
                push_data_q <= '0;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
            end else begin
                state_q     <= state_d;
                shreg_q     <= shreg_d;
                bit_cnt_q   <= bit_cnt_d;
                com_cnt_q   <= com_cnt_d;
                byte_idx_q  <= byte_idx_d;
                word_q      <= word_d;
                push_q      <= push_d;
                push_data_q <= push_data_d;
                wr_ptr_q    <= wr_ptr_d;
                rd_ptr_q    <= rd_ptr_d;
                count_q     <= count_d;
            end
        end
    end

    logic        sel_q, sel_d;
    logic [31:0] data_out_q, data_out_d;
    logic        valid_out_q, valid_out_d;
    logic        locked_q, locked_d;
    logic        overflow_q, overflow_d;

    // Only the lane whose turn it is may be popped, preserving order under skew.
    always_comb begin
        fifo_pop    = 2'b00;
        sel_d       = sel_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        if (fifo_nonempty[sel_q]) begin
            fifo_pop[sel_q] = 1'b1;
            data_out_d      = fifo_rd_data[sel_q];
            valid_out_d     = 1'b1;
            sel_d           = ~sel_q;
        end
    end

    always_comb begin
        locked_d   = &lane_locked;
        overflow_d = overflow_q | (|overflow_hit);
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            sel_q       <= 1'b0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            locked_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            locked_q    <= locked_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.locked    = locked_q;
    assign bus.overflow  = overflow_q;

`ifdef PHY_RX_WORD_COUNT_EN
    logic [15:0] word_count_q, word_count_d;

    always_comb begin
        word_count_d = word_count_q;
        if (valid_out_d && word_count_q != 16'hFFFF)
            word_count_d = word_count_q + 16'd1;
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset)
            word_count_q <= '0;
        else
            word_count_q <= word_count_d;
    end

    assign bus.word_count = word_count_q;
`endif
endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Scoreboard bench for phy_rx_deserializer: directed lock/order/skew/overflow/reset
// scenarios plus randomized word bursts checked against an interleaving lane model.
module tb_phy_rx_deserializer;
    localparam logic [7:0] COM = 8'hBC;

    logic clk_32f = 1'b0;
    logic reset;

    phy_rx_deserializer_if bus();

    phy_rx_deserializer dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 clk_32f = ~clk_32f;

    bit          q0[$];
    bit          q1[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_words  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    endtask

    task automatic push_byte(input int lane, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            if (lane == 0) q0.push_back(b[i]);
            else           q1.push_back(b[i]);
        end
    endtask

    task automatic push_word(input int lane, input logic [31:0] w);
        for (int k = 3; k >= 0; k--) push_byte(lane, w[k*8 +: 8]);
    endtask

    task automatic push_ones(input int lane, input int n);
        for (int i = 0; i < n; i++) begin
            if (lane == 0) q0.push_back(1'b1);
            else           q1.push_back(1'b1);
        end
    endtask

    // One serial bit per lane; an empty lane idles with an aligned COM byte.
    task automatic step();
        if (q0.size() == 0) push_byte(0, COM);
        if (q1.size() == 0) push_byte(1, COM);
        @(negedge clk_32f);
        bus.data_in_0 = q0.pop_front();
        bus.data_in_1 = q1.pop_front();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic drain();
        while (q0.size() != 0 || q1.size() != 0) step();
    endtask

    task automatic settle();
        drain();
        repeat (8) step();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        do w = $urandom; while (w[31:24] == COM);
        if ($urandom_range(0, 3) == 0) w[$urandom_range(0, 2)*8 +: 8] = COM;
        return w;
    endfunction

    // Monitor: every presented word must be the next one the model predicted.
    always @(posedge clk_32f) begin
        #1;
        if (reset === 1'b1 && bus.valid_out === 1'b1) begin
            n_words++;
            $display("word %0d out: data=0x%08h", n_words, bus.data_out);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: actual data_out=0x%08h valid_out=1, required no word", bus.data_out);
            end else begin
                check("word_order", bus.data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a[4];
        logic [31:0] b[5];
        logic [31:0] wl0[$];
        logic [31:0] wl1[$];

        reset = 1'b0;
        bus.data_in_0 = 1'b1;
        bus.data_in_1 = 1'b1;
        #2;
        check("reset_data_out", bus.data_out, 32'h0);
        check("reset_valid_out", 32'(bus.valid_out), 32'h0);
        check("reset_locked", 32'(bus.locked), 32'h0);
        check("reset_overflow", 32'(bus.overflow), 32'h0);
        repeat (3) @(posedge clk_32f);
        #1;
        reset = 1'b1;

        // Lock at an odd bit offset; lane 1 reaches its 4th COM one byte later.
        push_ones(0, 3);
        for (int i = 0; i < 4; i++) push_byte(0, COM);
        push_ones(1, 3);
        push_byte(1, 8'h00);
        for (int i = 0; i < 4; i++) push_byte(1, COM);
        repeat (43) step();
        check("lock_not_yet", 32'(bus.locked), 32'h0);
        step();
        check("lock_asserted", 32'(bus.locked), 32'h1);
        drain();

        // Aligned pair: exact two-edge latency, lane 0 first.
        exp_q.push_back(32'h11223344);
        exp_q.push_back(32'h55667788);
        push_word(0, 32'h11223344);
        push_word(1, 32'h55667788);
        repeat (32) step();
        step();
        check("latency_edge1_valid", 32'(bus.valid_out), 32'h0);
        step();
        check("latency_edge2_valid", 32'(bus.valid_out), 32'h1);
        check("latency_edge2_data", bus.data_out, 32'h11223344);
        step();
        check("second_word_data", bus.data_out, 32'h55667788);

        // Skew: lane 1 word completes 24 bits ahead of lane 0.
        exp_q.push_back(32'hA1B2C3D4);
        exp_q.push_back(32'h0FBC0EBC);
        for (int i = 0; i < 3; i++) push_byte(0, COM);
        push_word(0, 32'hA1B2C3D4);
        push_word(1, 32'h0FBC0EBC);
        settle();
        check("skew_no_overflow", 32'(bus.overflow), 32'h0);
        check("skew_drained", 32'(exp_q.size()), 32'h0);

        // Overflow: lane 1 fills its FIFO with lane 0 idle, then one more word.
        for (int i = 0; i < 5; i++) b[i] = 32'h20000000 + 32'(i + 1);
        for (int i = 0; i < 4; i++) a[i] = 32'h30000000 + 32'(i);
        for (int i = 0; i < 4; i++) push_word(1, b[i]);
        settle();
        check("full_no_overflow", 32'(bus.overflow), 32'h0);
        push_word(1, b[4]);
        settle();
        check("overflow_set", 32'(bus.overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(a[i]);
            exp_q.push_back(b[i]);
            push_word(0, a[i]);
        end
        settle();
        check("overflow_sticky", 32'(bus.overflow), 32'h1);
        check("overflow_drained", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset mid-word, no clock edge while asserted.
        push_word(0, 32'h44556677);
        push_word(1, 32'h66778899);
        repeat (12) step();
        check("pre_reset_locked", 32'(bus.locked), 32'h1);
        #2;
        reset = 1'b0;
        n_words = 0;
        #1;
        check("async_data_out", bus.data_out, 32'h0);
        check("async_valid_out", 32'(bus.valid_out), 32'h0);
        check("async_locked", 32'(bus.locked), 32'h0);
        check("async_overflow", 32'(bus.overflow), 32'h0);
`ifdef PHY_RX_WORD_COUNT_EN
        check("async_word_count", 32'(bus.word_count), 32'h0);
`endif
        q0.delete();
        q1.delete();
        reset = 1'b1;

        // Relock; lane 0 data before lock is ignored and 0x00 breaks its sync.
        push_word(0, 32'h11223344);
        push_byte(0, COM);
        push_byte(0, COM);
        push_byte(0, 8'h00);
        for (int i = 0; i < 4; i++) push_byte(0, COM);
        for (int i = 0; i < 11; i++) push_byte(1, COM);
        repeat (88) step();
        check("relock_not_yet", 32'(bus.locked), 32'h0);
        step();
        check("relock_asserted", 32'(bus.locked), 32'h1);
        drain();

        // Random bursts of four words per lane with random idle gaps.
        for (int burst = 0; burst < 6; burst++) begin
            wl0.delete();
            wl1.delete();
            for (int w = 0; w < 4; w++) begin
                wl0.push_back(rand_word());
                wl1.push_back(rand_word());
            end
            for (int w = 0; w < 4; w++) begin
                exp_q.push_back(wl0[w]);
                exp_q.push_back(wl1[w]);
            end
            for (int w = 0; w < 4; w++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) push_byte(0, COM);
                push_word(0, wl0[w]);
                for (int g = $urandom_range(0, 2); g > 0; g--) push_byte(1, COM);
                push_word(1, wl1[w]);
            end
            settle();
        end
        check("random_no_overflow", 32'(bus.overflow), 32'h0);
        check("random_drained", 32'(exp_q.size()), 32'h0);
`ifdef PHY_RX_WORD_COUNT_EN
        check("word_count", 32'(bus.word_count), 32'(n_words));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
